// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage: memory op encoding,
// the pipeline Signals bundle and the VRAM window geometry.
package mem_access_pkg;

    localparam logic [31:0] VRAM_BASE  = 32'h8000_0000;
    localparam int          VRAM_WORDS = 128;
    localparam int          VRAM_AW    = $clog2(VRAM_WORDS);
    localparam logic [31:0] VRAM_END   = VRAM_BASE + 32'(VRAM_WORDS * 4);

    typedef enum logic [3:0] {
        MemNone, LoadB, LoadBU, LoadH, LoadHU, LoadW, StoreB, StoreH, StoreW
    } MemOp;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wback;
        logic [31:0] wdata;
        MemOp        mop;
        logic [31:0] maddr;
        logic [31:0] mstore;
    } Signals;

    function automatic logic is_load(input MemOp op);
        return (op == LoadB) || (op == LoadBU) || (op == LoadH) ||
               (op == LoadHU) || (op == LoadW);
    endfunction

    function automatic logic is_store(input MemOp op);
        return (op == StoreB) || (op == StoreH) || (op == StoreW);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-RAM ready/valid bus plus the VRAM write port driven by the memory stage.
interface mem_access_if;
    import mem_access_pkg::*;

    logic               mem_req;
    logic               mem_we;
    logic [29:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_be;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               vram_we;
    logic [VRAM_AW-1:0] vram_addr;
    logic [31:0]        vram_wdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output vram_we, vram_addr, vram_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  vram_we, vram_addr, vram_wdata
    );

endinterface

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  MemOp        mop,
    output logic [31:0] word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (mop)
            LoadB:   word = {{24{byte_sel[7]}}, byte_sel};
            LoadBU:  word = {24'b0, byte_sel};
            LoadH:   word = {{16{half_sel[15]}}, half_sel};
            LoadHU:  word = {16'b0, half_sel};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: classifies the Execute op, runs RAM accesses through a small
// request FSM, writes words into VRAM and forwards the merged result to WriteBack.
module mem_access
    import mem_access_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  Signals       i_signals,
    output logic         o_stall,
    output Signals       o_signals,
    output logic         o_misaligned,
    mem_access_if.master bus
);

    mem_state_t  state, next_state;
    MemOp        mop;
    logic [31:0] addr;
    logic        load_op, store_op, misaligned, in_vram, illegal, vram_store, ram_op;
    logic        done, emit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, load_word;
    Signals      emit_sig;

    assign mop  = i_signals.mop;
    assign addr = i_signals.maddr;

    // Upstream holds i_signals during a stall, so the op is never re-latched here.
    always_comb begin
        load_op    = is_load(mop);
        store_op   = is_store(mop);
        misaligned = 1'b0;
        case (mop)
            LoadW, StoreW:         misaligned = (addr[1:0] != 2'b00);
            LoadH, LoadHU, StoreH: misaligned = addr[0];
            default:               misaligned = 1'b0;
        endcase
        in_vram    = (addr >= VRAM_BASE) && (addr < VRAM_END);
        illegal    = misaligned ||
                     (in_vram && (load_op || (mop == StoreB) || (mop == StoreH)));
        vram_store = (mop == StoreW) && in_vram && !illegal;
        ram_op     = i_signals.valid && (load_op || store_op) && !illegal && !vram_store;
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_signals.mstore;
        case (mop)
            StoreB: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{i_signals.mstore[7:0]}};
            end
            StoreH: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {2{i_signals.mstore[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = i_signals.mstore;
            end
        endcase
    end

    load_align u_load_align (
        .rdata (bus.mem_rdata),
        .lane  (addr[1:0]),
        .mop   (mop),
        .word  (load_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Stall releases in the completing cycle so upstream advances on the emit edge.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        o_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (ram_op) begin
                    next_state = REQ;
                    o_stall    = 1'b1;
                end
            end
            REQ: begin
                if (bus.mem_ready && (store_op || bus.mem_rvalid)) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else if (bus.mem_ready) begin
                    next_state = WAIT;
                    o_stall    = 1'b1;
                end else begin
                    o_stall = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!rst_n) o_stall = 1'b0;

        emit           = done || ((state == IDLE) && i_signals.valid && !ram_op);
        emit_sig       = i_signals;
        emit_sig.valid = 1'b1;
        if (load_op && !illegal)  emit_sig.wdata = load_word;
        if (store_op || illegal)  emit_sig.wback = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_signals      <= '0;
            o_misaligned   <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_be     <= '0;
            bus.vram_we    <= 1'b0;
            bus.vram_addr  <= '0;
            bus.vram_wdata <= '0;
        end else begin
            o_signals    <= emit ? emit_sig : '0;
            o_misaligned <= (state == IDLE) && i_signals.valid && illegal;
            bus.vram_we  <= (state == IDLE) && i_signals.valid && vram_store;
            if ((state == IDLE) && i_signals.valid && vram_store) begin
                bus.vram_addr  <= addr[VRAM_AW+1:2];
                bus.vram_wdata <= i_signals.mstore;
            end
            if ((state == IDLE) && ram_op) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= store_op;
                bus.mem_addr  <= addr[31:2];
                bus.mem_be    <= st_be;
                bus.mem_wdata <= st_wdata;
            end else if ((state == REQ) && bus.mem_ready) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected WriteBack packets are queued when an op
// is driven and compared as the stage emits them; bus/VRAM/stall behaviour is checked inline.
module tb_mem_access;
    import mem_access_pkg::*;

    typedef struct {
        Signals sig;
        logic   mis;
        logic   chk_wdata;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    Signals i_signals;
    logic   o_stall;
    Signals o_signals;
    logic   o_misaligned;
    mem_access_if bus();

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic snap_we;
    logic [3:0] snap_be;
    logic [31:0] snap_wdata;
    logic [29:0] snap_addr;

    mem_access dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_signals    (i_signals),
        .o_stall      (o_stall),
        .o_signals    (o_signals),
        .o_misaligned (o_misaligned),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic Signals mk(input logic [31:0] pc, input MemOp op, input logic [31:0] a,
                                  input logic [31:0] st, input logic [31:0] wd);
        Signals s;
        s        = '0;
        s.valid  = 1'b1;
        s.pc     = pc;
        s.rd     = pc[6:2];
        s.wback  = 1'b1;
        s.wdata  = wd;
        s.mop    = op;
        s.maddr  = a;
        s.mstore = st;
        return s;
    endfunction

    function automatic exp_t mkExp(input Signals s, input logic wback, input logic [31:0] wd,
                                   input logic mis, input logic chk);
        exp_t e;
        e.sig       = s;
        e.sig.wback = wback;
        e.sig.wdata = wd;
        e.mis       = mis;
        e.chk_wdata = chk;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_signals.valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_emit", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_pc", o_signals.pc, mon_e.sig.pc);
                checkOutput("sb_rd", o_signals.rd, mon_e.sig.rd);
                checkOutput("sb_wback", o_signals.wback, mon_e.sig.wback);
                checkOutput("sb_mop", o_signals.mop, mon_e.sig.mop);
                checkOutput("sb_misaligned", o_misaligned, mon_e.mis);
                if (mon_e.chk_wdata) checkOutput("sb_wdata", o_signals.wdata, mon_e.sig.wdata);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op that must not stall; returns at the negedge of its cycle.
    task automatic applyStimulus(input string tag, input Signals s, input exp_t e);
        i_signals = s;
        sb.push_back(e);
        @(negedge clk);
        checkOutput({tag, "_nostall"}, o_stall, 0);
    endtask

    task automatic runRamOp(input Signals s, input int ready_k, input int rvalid_k,
                            input logic [31:0] rdata, output int stalls, output int reqs);
        bit finished = 0;
        stalls    = 0;
        reqs      = 0;
        i_signals = s;
        for (int k = 0; k <= 20 && !finished; k++) begin
            bus.mem_ready  = (k == ready_k);
            bus.mem_rvalid = (k == rvalid_k);
            bus.mem_rdata  = rdata;
            @(negedge clk);
            if (k == 1) begin
                snap_we    = bus.mem_we;
                snap_be    = bus.mem_be;
                snap_wdata = bus.mem_wdata;
                snap_addr  = bus.mem_addr;
            end
            if (bus.mem_req) reqs++;
            if (!o_stall) finished = 1;
            else begin
                stalls++;
                nextCycle();
            end
        end
        if (!finished) checkOutput("ram_timeout", 0, 1);
        nextCycle();
        i_signals      = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        Signals s;
        int     st, rq;

        rst_n          = 1'b0;
        i_signals      = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #2;
        checkOutput("rst_valid", o_signals.valid, 0);
        checkOutput("rst_stall", o_stall, 0);
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_vram_we", bus.vram_we, 0);
        checkOutput("rst_misaligned", o_misaligned, 0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Pass-through op.
        s = mk(32'h10, MemNone, 32'h0, 32'h0, 32'h5);
        applyStimulus("t1", s, mkExp(s, 1'b1, 32'h5, 1'b0, 1'b1));
        nextCycle();
        i_signals = '0;
        repeat (2) nextCycle();

        s = mk(32'h20, LoadBU, 32'h103, 32'h0, 32'h0);
        sb.push_back(mkExp(s, 1'b1, 32'h0000_0080, 1'b0, 1'b1));
        runRamOp(s, 1, 3, 32'h80AA_BBCC, st, rq);
        checkOutput("t2_stalls", st, 3);
        checkOutput("t2_reqs", rq, 1);

        s = mk(32'h24, LoadH, 32'h102, 32'h0, 32'h0);
        sb.push_back(mkExp(s, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1));
        runRamOp(s, 1, 1, 32'h8001_0000, st, rq);
        checkOutput("t3_stalls", st, 1);
        checkOutput("t3_reqs", rq, 1);
        checkOutput("t3_load_we", snap_we, 0);

        s = mk(32'h28, StoreB, 32'h201, 32'hAB, 32'h77);
        sb.push_back(mkExp(s, 1'b0, 32'h77, 1'b0, 1'b1));
        runRamOp(s, 4, -1, 32'h0, st, rq);
        checkOutput("t4_stalls", st, 4);
        checkOutput("t4_reqs", rq, 4);
        checkOutput("t4_we", snap_we, 1);
        checkOutput("t4_be", snap_be, 4'b0010);
        checkOutput("t4_wdata", snap_wdata, 32'hABAB_ABAB);
        checkOutput("t4_addr", snap_addr, 30'h80);

        s = mk(32'h2C, StoreH, 32'h302, 32'h5555_1234, 32'h0);
        sb.push_back(mkExp(s, 1'b0, 32'h0, 1'b0, 1'b1));
        runRamOp(s, 1, -1, 32'h0, st, rq);
        checkOutput("t4h_stalls", st, 1);
        checkOutput("t4h_be", snap_be, 4'b1100);
        checkOutput("t4h_wdata", snap_wdata, 32'h1234_1234);
        checkOutput("t4h_addr", snap_addr, 30'hC0);

        s = mk(32'h30, LoadW, 32'h104, 32'h0, 32'h0);
        sb.push_back(mkExp(s, 1'b1, 32'h1234_5678, 1'b0, 1'b1));
        runRamOp(s, 2, 2, 32'h1234_5678, st, rq);
        checkOutput("t4w_stalls", st, 2);
        checkOutput("t4w_reqs", rq, 2);
        checkOutput("t4w_addr", snap_addr, 30'h41);

        // VRAM word store followed by illegal accesses, back to back.
        s = mk(32'h40, StoreW, 32'h8000_0014, 32'hDEAD_BEEF, 32'h0);
        applyStimulus("t5_vram", s, mkExp(s, 1'b0, 32'h0, 1'b0, 1'b1));
        checkOutput("t5_vram_we_pre", bus.vram_we, 0);
        nextCycle();
        s = mk(32'h44, LoadW, 32'h102, 32'h0, 32'h0);
        applyStimulus("t5_mis", s, mkExp(s, 1'b0, 32'h0, 1'b1, 1'b0));
        checkOutput("t5_vram_we", bus.vram_we, 1);
        checkOutput("t5_vram_addr", bus.vram_addr, 5);
        checkOutput("t5_vram_wdata", bus.vram_wdata, 32'hDEAD_BEEF);
        nextCycle();
        s = mk(32'h48, StoreH, 32'h8000_0000, 32'h1, 32'h0);
        applyStimulus("t5_vsh", s, mkExp(s, 1'b0, 32'h0, 1'b1, 1'b0));
        checkOutput("t5_vram_we_once", bus.vram_we, 0);
        checkOutput("t5_mis_no_req", bus.mem_req, 0);
        nextCycle();
        s = mk(32'h4C, LoadW, 32'h8000_0010, 32'h0, 32'h0);
        applyStimulus("t5_vld", s, mkExp(s, 1'b0, 32'h0, 1'b1, 1'b0));
        checkOutput("t5_vsh_no_vram", bus.vram_we, 0);
        checkOutput("t5_vsh_no_req", bus.mem_req, 0);
        nextCycle();
        i_signals = '0;
        @(negedge clk);
        checkOutput("t5_vld_no_vram", bus.vram_we, 0);
        checkOutput("t5_vld_no_req", bus.mem_req, 0);
        nextCycle();

        // Reset while waiting for load data.
        i_signals     = mk(32'h50, LoadW, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        nextCycle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("t6_req_in_req", bus.mem_req, 1);
        nextCycle();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("t6_stall_wait", o_stall, 1);
        #1;
        rst_n     = 1'b0;
        i_signals = '0;
        #1;
        checkOutput("t6_rst_stall", o_stall, 0);
        checkOutput("t6_rst_req", bus.mem_req, 0);
        checkOutput("t6_rst_valid", o_signals.valid, 0);
        checkOutput("t6_rst_addr", bus.mem_addr, 0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        s = mk(32'h54, LoadB, 32'h101, 32'h0, 32'h0);
        sb.push_back(mkExp(s, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b1));
        runRamOp(s, 1, 1, 32'h0000_F000, st, rq);
        checkOutput("t6_after_stalls", st, 1);

        repeat (4) nextCycle();
        checkOutput("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
